// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader: streams instruction words into memory, then releases the CPU. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        proc_reset,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        begin_session;
  logic        hit_limit;
  logic [16:0] count_inc;

  assign count_inc = {1'b0, word_count} + 17'd1;
  assign hit_limit = (count_inc == MAX_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    proc_reset    = 1'b1;
    done          = 1'b0;
    accept        = 1'b0;
    begin_session = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next    = S_LOAD;
          begin_session = 1'b1;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (in_last || hit_limit) state_next = S_RELEASE;
        end
      end
      // One guard cycle so the final memory write lands before the CPU runs.
      S_RELEASE: state_next = S_RUN;
      S_RUN: begin
        proc_reset = 1'b0;
        done       = 1'b1;
        if (start) begin
          state_next    = S_LOAD;
          begin_session = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_write  <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      word_count <= 16'd0;
      overflow   <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      if (begin_session) begin
        word_count <= 16'd0;
        overflow   <= 1'b0;
      end
      if (accept) begin
        mem_write  <= 1'b1;
        mem_wdata  <= in_data;
        mem_addr   <= BASE_ADDR + {14'd0, word_count, 2'b00};
        word_count <= count_inc[15:0];
        if (hit_limit && !in_last) overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 256, capacity in 32-bit words; legal range 2..65535.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  one-cycle request to begin a load session.
REQ-006 Port in_valid  input  1  upstream word present on in_data.
REQ-007 Port in_data  input  32  instruction word.
REQ-008 Port in_last  input  1  qualifies in_data as the final word of the program.
REQ-009 Port in_ready  output  1  loader can accept a word this cycle.
REQ-010 Port mem_addr  output  32  instruction-memory write address, in bytes.
REQ-011 Port mem_wdata  output  32  instruction-memory write data.
REQ-012 Port mem_write  output  1  instruction-memory write strobe, one cycle per word.
REQ-013 Port proc_reset  output  1  holds the processor PC in reset while high.
REQ-014 Port done  output  1  program loaded and processor released.
REQ-015 Port overflow  output  1  sticky flag: MAX_WORDS reached without in_last.
REQ-016 Port word_count  output  16  number of words written in the current or last session.

Function
REQ-017 The loader SHALL implement states IDLE, LOAD, RELEASE and RUN.
REQ-018 IDLE: in_ready=0, proc_reset=1; start=1 -> LOAD; word_count and overflow cleared on that edge.
REQ-019 LOAD: in_ready=1; a word is accepted on any edge where in_valid=1 and in_ready=1.
REQ-020 On each accepted word, the next cycle SHALL show mem_write=1, mem_wdata=accepted in_data, mem_addr=BASE_ADDR+4*(word_count before increment); word_count increments on the same edge.
REQ-021 mem_write SHALL be low in every cycle not directly following an accept; mem_addr and mem_wdata hold their last values.
REQ-022 Accepted word with in_last=1 -> RELEASE; in_ready deasserts the following cycle.
REQ-023 Accept that brings word_count to MAX_WORDS with in_last=0 -> RELEASE and overflow=1.
REQ-024 in_last=1 together with in_valid=0 SHALL be ignored.
REQ-025 RELEASE lasts exactly one cycle with proc_reset=1 and in_ready=0, so the last mem_write completes before the processor is released; then -> RUN.
REQ-026 RUN: proc_reset=0, done=1, in_ready=0; word_count and overflow hold.
REQ-027 start=1 in RUN -> LOAD: proc_reset=1, done=0 on the next cycle, word_count and overflow cleared.
REQ-028 start SHALL be ignored in LOAD and RELEASE.
REQ-029 Address arithmetic is 32-bit unsigned and wraps modulo 2^32; word_count never exceeds MAX_WORDS.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, proc_reset=1, in_ready=0, mem_write=0, done=0, overflow=0, word_count=0, mem_addr=BASE_ADDR, mem_wdata=0.
REQ-031 reset asserted mid-LOAD SHALL abort the session; no further mem_write occurs until a new start.
REQ-032 After reset deasserts, the first state change occurs on a clk edge; start is required to leave IDLE.

Verification
REQ-033 Reset, start, 3 words 02128020/8C090004/00000000 (last on 3rd), in_valid held high -> 3 consecutive mem_write at addresses 0/4/8 with matching data, RELEASE for 1 cycle, then proc_reset=0, done=1, word_count=3.
REQ-034 Same 3 words with in_valid toggling 1,0,1,0,1 -> writes only on cycles after accepts; addresses 0/4/8; no gaps in the address sequence.
REQ-035 MAX_WORDS=4, 6 words offered with no in_last -> exactly 4 writes (0..C), overflow=1, in_ready=0 after the 4th accept, done=1.
REQ-036 reset pulse after the 2nd accept of a 5-word session -> all outputs at reset values asynchronously; no further mem_write; a new start then writes from address 0 again.
REQ-037 Completed session (done=1), then start plus 1 word with in_last -> proc_reset=1 during reload, single write at BASE_ADDR, word_count=1, done=1 again.
REQ-038 BASE_ADDR=32'hFFFF_FFF8, 3 words -> addresses FFFFFFF8, FFFFFFFC, 00000000 (wrap).
